// File: rtl/cpu_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_controller_if
//  Purpose  : Groups the sequencer's run/decode inputs and the strobes it
//             drives towards the 8-bit RISC datapath.
//  Modports : master - the sequencer. It samples ena/opcode/zero and drives
//                      the strobes.
//             slave  - the datapath side. It drives ena/opcode/zero and
//                      consumes the strobes.
//  Signals  : ena, opcode[2:0], zero         (datapath -> sequencer)
//             rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc,
//             datactl_ena, halt              (sequencer -> datapath)
//  Revision : 1.0  initial release
// ============================================================================
interface cpu_controller_if;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       rd;
  logic       wr;
  logic       load_ir;
  logic       inc_pc;
  logic       load_pc;
  logic       alu_ena;
  logic       load_acc;
  logic       datactl_ena;
  logic       halt;

  modport master (
    input  ena, opcode, zero,
    output rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt
  );

  modport slave (
    output ena, opcode, zero,
    input  rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt
  );
endinterface
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_controller
//  Purpose  : Instruction-sequencing FSM for the 8-bit RISC core. Every
//             instruction runs as a fixed 8-clock sequence S0..S7:
//             two IR byte fetches, a decode clock, then execute.
//  Ports    : clk   - clock; all state changes on the rising edge
//             rst_n - asynchronous active-low reset
//             bus   - cpu_controller_if.master (ena/opcode/zero in, strobes out)
//  Params   : HLT_STICKY - 1: HLT parks the FSM in HALTED until reset.
//                          0: halt pulses for the S3 clock only and
//                             execution continues.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_controller #(
  parameter bit HLT_STICKY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_controller_if.master  bus
);

  localparam logic [2:0] c_op_hlt = 3'b000;
  localparam logic [2:0] c_op_skz = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_and = 3'b011;
  localparam logic [2:0] c_op_xor = 3'b100;
  localparam logic [2:0] c_op_lda = 3'b101;
  localparam logic [2:0] c_op_sto = 3'b110;
  localparam logic [2:0] c_op_jmp = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  state_t     r_state, w_state_next;
  logic [2:0] r_op, w_op_next;
  logic       r_zero, w_zero_next;
  logic       w_alu_op;

  logic r_rd, r_wr, r_load_ir, r_inc_pc, r_load_pc;
  logic r_alu_ena, r_load_acc, r_datactl_ena, r_halt;
  logic w_rd, w_wr, w_load_ir, w_inc_pc, w_load_pc;
  logic w_alu_ena, w_load_acc, w_datactl_ena, w_halt;

  // Outputs are registered: each strobe is decoded from the state being
  // entered, so it is valid for the whole of that state. The decode uses
  // the op/zero values that will hold in that state. This lets S3 see the
  // opcode captured on the S2->S3 edge and S5 see the zero flag captured
  // on the S4->S5 edge.
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_zero_next  = r_zero;

    case (r_state)
      ST_IDLE:   if (bus.ena) w_state_next = ST_S0;
      ST_HALTED: w_state_next = ST_HALTED;
      default: begin
        if (!bus.ena) begin
          w_state_next = ST_IDLE;
        end else begin
          case (r_state)
            ST_S0: w_state_next = ST_S1;
            ST_S1: w_state_next = ST_S2;
            ST_S2: begin
              w_state_next = ST_S3;
              w_op_next    = bus.opcode;
            end
            ST_S3: w_state_next = (HLT_STICKY && (r_op == c_op_hlt)) ? ST_HALTED : ST_S4;
            ST_S4: begin
              w_state_next = ST_S5;
              w_zero_next  = bus.zero;
            end
            ST_S5:   w_state_next = ST_S6;
            ST_S6:   w_state_next = ST_S7;
            ST_S7:   w_state_next = ST_S0;
            default: w_state_next = ST_IDLE;
          endcase
        end
      end
    endcase

    w_alu_op = (w_op_next == c_op_add) || (w_op_next == c_op_and) ||
               (w_op_next == c_op_xor) || (w_op_next == c_op_lda);

    w_rd          = 1'b0;
    w_wr          = 1'b0;
    w_load_ir     = 1'b0;
    w_inc_pc      = 1'b0;
    w_load_pc     = 1'b0;
    w_alu_ena     = 1'b0;
    w_load_acc    = 1'b0;
    w_datactl_ena = 1'b0;
    w_halt        = 1'b0;

    case (w_state_next)
      ST_S0, ST_S1: begin
        w_rd      = 1'b1;
        w_load_ir = 1'b1;
        w_inc_pc  = 1'b1;
      end
      ST_S3: w_halt = (w_op_next == c_op_hlt);
      ST_S4: begin
        w_rd          = w_alu_op;
        w_datactl_ena = (w_op_next == c_op_sto);
        w_load_pc     = (w_op_next == c_op_jmp);
      end
      ST_S5: begin
        w_rd          = w_alu_op;
        w_alu_ena     = w_alu_op;
        w_datactl_ena = (w_op_next == c_op_sto);
        w_wr          = (w_op_next == c_op_sto);
        w_load_pc     = (w_op_next == c_op_jmp);
        w_inc_pc      = (w_op_next == c_op_jmp) || ((w_op_next == c_op_skz) && w_zero_next);
      end
      ST_S6: begin
        w_load_acc    = w_alu_op;
        w_datactl_ena = (w_op_next == c_op_sto);
      end
      // Second skip increment: together with S5 this steps the PC past the
      // two-byte instruction that follows SKZ.
      ST_S7:     w_inc_pc = (w_op_next == c_op_skz) && w_zero_next;
      ST_HALTED: w_halt   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_op          <= 3'b000;
      r_zero        <= 1'b0;
      r_rd          <= 1'b0;
      r_wr          <= 1'b0;
      r_load_ir     <= 1'b0;
      r_inc_pc      <= 1'b0;
      r_load_pc     <= 1'b0;
      r_alu_ena     <= 1'b0;
      r_load_acc    <= 1'b0;
      r_datactl_ena <= 1'b0;
      r_halt        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_op          <= w_op_next;
      r_zero        <= w_zero_next;
      r_rd          <= w_rd;
      r_wr          <= w_wr;
      r_load_ir     <= w_load_ir;
      r_inc_pc      <= w_inc_pc;
      r_load_pc     <= w_load_pc;
      r_alu_ena     <= w_alu_ena;
      r_load_acc    <= w_load_acc;
      r_datactl_ena <= w_datactl_ena;
      r_halt        <= w_halt;
    end
  end

  assign bus.rd          = r_rd;
  assign bus.wr          = r_wr;
  assign bus.load_ir     = r_load_ir;
  assign bus.inc_pc      = r_inc_pc;
  assign bus.load_pc     = r_load_pc;
  assign bus.alu_ena     = r_alu_ena;
  assign bus.load_acc    = r_load_acc;
  assign bus.datactl_ena = r_datactl_ena;
  assign bus.halt        = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_controller
//  Purpose  : Directed self-checking bench for cpu_controller. Drives a
//             sticky-HLT instance (dut) and a non-sticky instance (dut_ns)
//             with identical stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_controller;

  // Strobe vector layout:
  // {rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt}
  localparam logic [8:0] RD    = 9'h100;
  localparam logic [8:0] WR    = 9'h080;
  localparam logic [8:0] LIR   = 9'h040;
  localparam logic [8:0] INC   = 9'h020;
  localparam logic [8:0] LPC   = 9'h010;
  localparam logic [8:0] ALU   = 9'h008;
  localparam logic [8:0] LACC  = 9'h004;
  localparam logic [8:0] DCTL  = 9'h002;
  localparam logic [8:0] HALT  = 9'h001;
  localparam logic [8:0] NONE  = 9'h000;
  localparam logic [8:0] FETCH = RD | LIR | INC;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  int         errors;
  int         checks;

  cpu_controller_if bus ();
  cpu_controller_if bus_ns ();

  assign bus.ena       = ena;
  assign bus.opcode    = opcode;
  assign bus.zero      = zero;
  assign bus_ns.ena    = ena;
  assign bus_ns.opcode = opcode;
  assign bus_ns.zero   = zero;

  cpu_controller #(.HLT_STICKY(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  cpu_controller #(.HLT_STICKY(1'b0)) dut_ns (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ns.master)
  );

  logic [8:0] out1;
  logic [8:0] out2;
  assign out1 = {bus.rd, bus.wr, bus.load_ir, bus.inc_pc, bus.load_pc,
                 bus.alu_ena, bus.load_acc, bus.datactl_ena, bus.halt};
  assign out2 = {bus_ns.rd, bus_ns.wr, bus_ns.load_ir, bus_ns.inc_pc, bus_ns.load_pc,
                 bus_ns.alu_ena, bus_ns.load_acc, bus_ns.datactl_ena, bus_ns.halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [8:0] exp);
    tick();
    check(tag, out1, exp);
  endtask

  task automatic step2(input string tag, input logic [8:0] exp1, input logic [8:0] exp2);
    tick();
    check({tag, "_sticky"}, out1, exp1);
    check({tag, "_nonsticky"}, out2, exp2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    ena    = 1'b0;
    opcode = OP_ADD;
    zero   = 1'b0;

    // Reset held, then ena low for 10 clocks: everything stays quiet.
    tick(); tick(); tick();
    check("reset_sticky", out1, NONE);
    check("reset_nonsticky", out2, NONE);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("idle", NONE);

    // ADD: strobes appear one clock after ena is sampled high.
    ena = 1'b1;
    opcode = OP_ADD;
    step("add_s0", FETCH);
    step("add_s1", FETCH);
    step("add_s2", NONE);
    step("add_s3", NONE);
    step("add_s4", RD);
    step("add_s5", RD | ALU);
    step("add_s6", LACC);
    step("add_s7", NONE);

    // STO: datactl_ena over S4..S6, wr only in S5, no rd after fetch.
    opcode = OP_STO;
    step("sto_s0", FETCH);
    step("sto_s1", FETCH);
    step("sto_s2", NONE);
    step("sto_s3", NONE);
    step("sto_s4", DCTL);
    step("sto_s5", DCTL | WR);
    step("sto_s6", DCTL);
    step("sto_s7", NONE);

    // SKZ with zero=1 at S4->S5: inc_pc in S5 and S7, even after zero drops.
    opcode = OP_SKZ;
    step("skz1_s0", FETCH);
    step("skz1_s1", FETCH);
    step("skz1_s2", NONE);
    step("skz1_s3", NONE);
    step("skz1_s4", NONE);
    zero = 1'b1;
    step("skz1_s5", INC);
    zero = 1'b0;
    step("skz1_s6", NONE);
    step("skz1_s7", INC);

    // SKZ with zero=0 at S4->S5: no skip, and a later zero=1 is ignored.
    step("skz0_s0", FETCH);
    step("skz0_s1", FETCH);
    step("skz0_s2", NONE);
    step("skz0_s3", NONE);
    step("skz0_s4", NONE);
    step("skz0_s5", NONE);
    zero = 1'b1;
    step("skz0_s6", NONE);
    step("skz0_s7", NONE);
    zero = 1'b0;

    // JMP: changing opcode to ADD during S4 has no effect.
    opcode = OP_JMP;
    step("jmp_s0", FETCH);
    step("jmp_s1", FETCH);
    step("jmp_s2", NONE);
    step("jmp_s3", NONE);
    step("jmp_s4", LPC);
    opcode = OP_ADD;
    step("jmp_s5", LPC | INC);
    step("jmp_s6", NONE);
    step("jmp_s7", NONE);

    // ADD aborted by dropping ena in S5: no load_acc, then restart from S0.
    step("abort_s0", FETCH);
    step("abort_s1", FETCH);
    step("abort_s2", NONE);
    step("abort_s3", NONE);
    step("abort_s4", RD);
    step("abort_s5", RD | ALU);
    ena = 1'b0;
    step("abort_idle0", NONE);
    step("abort_idle1", NONE);
    ena = 1'b1;
    step2("restart_s0", FETCH, FETCH);

    // HLT: the sticky instance parks with halt=1, the non-sticky one pulses.
    opcode = OP_HLT;
    step2("hlt_s1", FETCH, FETCH);
    step2("hlt_s2", NONE, NONE);
    step2("hlt_s3", HALT, HALT);
    step2("hlt_s4", HALT, NONE);
    step2("hlt_s5", HALT, NONE);
    step2("hlt_s6", HALT, NONE);
    step2("hlt_s7", HALT, NONE);
    opcode = OP_ADD;
    step2("hlt_next", HALT, FETCH);
    ena = 1'b0;
    step2("hlt_ena0", HALT, NONE);
    ena = 1'b1;
    step2("hlt_ena1", HALT, FETCH);

    // Asynchronous reset clears outputs before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sticky", out1, NONE);
    check("async_rst_nonsticky", out2, NONE);
    tick();
    check("rst_held", out1, NONE);
    rst_n = 1'b1;
    ena = 1'b0;
    step("post_rst_idle", NONE);
    ena = 1'b1;
    step2("post_rst_s0", FETCH, FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
